// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: FSM state encoding and the counter-width helper
// shared by the serial adder and any later serial datapath blocks.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// full_adder: one-bit combinational full adder made of two half adders.
// Ports: a, b, cin in; sum, cout out.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic s1, c1, c2;

  assign s1   = a ^ b;
  assign c1   = a & b;
  assign sum  = s1 ^ cin;
  assign c2   = s1 & cin;
  assign cout = c1 | c2;

endmodule

// File: rtl/serial_adder.sv
// serial_adder: WIDTH-bit a+b+cin, STEP bits per clock LSB-first, with a
// start/ready/done handshake. Ports: clk, rst_n, start, a, b, cin in;
// ready, busy, done, sum, carry out. SERIAL_ADDER_OVF_EN adds output ovf.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = (N > 1) ? clog2(N) : 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             step_en;
  logic             last;

  logic [STEP:0]    cc;
  logic [STEP-1:0]  ss;
  logic [WIDTH-1:0] full;

  assign cc[0] = c_q;

  for (genvar i = 0; i < STEP; i++) begin : g_slice
    full_adder u_fa (
      .a    (a_q[i]),
      .b    (b_q[i]),
      .cin  (cc[i]),
      .sum  (ss[i]),
      .cout (cc[i+1])
    );
  end

  // Earlier slices live in r_q; the newest slice enters at the MSB end,
  // so the complete sum is the new slice on top of r_q.
  if (N > 1) begin : g_res
    logic [WIDTH-STEP-1:0] r_q;
    assign full = {ss, r_q};
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_q <= '0;
      else if (step_en) r_q <= full[WIDTH-1:STEP];
    end
  end else begin : g_nores
    assign full = ss;
  end

  assign last = (cnt_q == CW'(N - 1));

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    step_en = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          a_d     = a;
          b_d     = b;
          c_d     = cin;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        step_en = 1'b1;
        a_d     = a_q >> STEP;
        b_d     = b_q >> STEP;
        c_d     = cc[STEP];
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          state_d = S_DONE;
          sum_d   = full;
          carry_d = cc[STEP];
`ifdef SERIAL_ADDER_OVF_EN
          // On the last step slice bit STEP-1 is sum bit WIDTH-1.
          ovf_d   = cc[STEP-1] ^ cc[STEP];
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else ovf_q <= ovf_d;
  end
  assign ovf = ovf_q;
`endif

  assign ready = (state_q == S_IDLE) || (state_q == S_DONE);
  assign busy  = (state_q == S_RUN);
  assign done  = (state_q == S_DONE);
  assign sum   = sum_q;
  assign carry = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed vectors for serial_adder at STEP=1 and STEP=4,
// plus hand-written mid-RUN start, mid-RUN reset and back-to-back cases.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       st8, ci8, rdy8, bsy8, dn8, cy8;
  logic [7:0] a8, b8, sum8;
  logic       st4, ci4, rdy4, bsy4, dn4, cy4;
  logic [7:0] a4, b4, sum4;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf8, ovf4;
`endif

  serial_adder #(.WIDTH(8), .STEP(1)) u8 (
    .clk(clk), .rst_n(rst_n), .start(st8),
    .a(a8), .b(b8), .cin(ci8),
    .ready(rdy8), .busy(bsy8), .done(dn8),
    .sum(sum8), .carry(cy8)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_adder #(.WIDTH(8), .STEP(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(st4),
    .a(a4), .b(b4), .cin(ci4),
    .ready(rdy4), .busy(bsy4), .done(dn4),
    .sum(sum4), .carry(cy4)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf4)
`endif
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       carry;
    logic       ovf;
  } vec_t;

  vec_t vecs[6];

  // Accept one operation on the STEP=1 instance and wait for done.
  task automatic op8(input logic [7:0] a, input logic [7:0] b,
                     input logic c, output int lat, output int win_bad);
    @(negedge clk);
    a8 = a; b8 = b; ci8 = c; st8 = 1'b1;
    @(posedge clk);
    #1 st8 = 1'b0;
    lat = -1;
    win_bad = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (dn8) begin
        lat = k;
        break;
      end
      if (!bsy8 || rdy8) win_bad++;
    end
  endtask

  initial begin
    int lat, wb, dones, k1, k2;
    logic [7:0] s_cap, s2_cap;
    logic c_cap, c2_cap;

    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[4] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[5] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};

    rst_n = 1'b0;
    st8 = 0; a8 = 0; b8 = 0; ci8 = 0;
    st4 = 0; a4 = 0; b4 = 0; ci4 = 0;
    #12;
    chk("rst_ready", {31'b0, rdy8}, 1);
    chk("rst_busy", {31'b0, bsy8}, 0);
    chk("rst_done", {31'b0, dn8}, 0);
    chk("rst_sum", {24'b0, sum8}, 0);
    chk("rst_carry", {31'b0, cy8}, 0);
    chk("rst4_ready", {31'b0, rdy4}, 1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      op8(vecs[i].a, vecs[i].b, vecs[i].cin, lat, wb);
      chk($sformatf("v%0d_latency", i), lat, 8);
      chk($sformatf("v%0d_busywin", i), wb, 0);
      chk($sformatf("v%0d_sum", i), {24'b0, sum8}, {24'b0, vecs[i].sum});
      chk($sformatf("v%0d_carry", i), {31'b0, cy8},
          {31'b0, vecs[i].carry});
`ifdef SERIAL_ADDER_OVF_EN
      chk($sformatf("v%0d_ovf", i), {31'b0, ovf8}, {31'b0, vecs[i].ovf});
`endif
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_done_pulse", i), {31'b0, dn8}, 0);
      chk($sformatf("v%0d_idle_ready", i), {31'b0, rdy8}, 1);
    end

    // start pulsed mid-RUN must be ignored
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; ci8 = 0; st8 = 1;
    @(posedge clk);
    #1 st8 = 0;
    dones = 0; lat = -1; s_cap = 0; c_cap = 0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      #1;
      if (k == 2) begin
        a8 = 8'hFF; b8 = 8'hFF; st8 = 1;
      end
      if (k == 3) st8 = 0;
      if (dn8) begin
        dones++;
        if (lat < 0) begin
          lat = k; s_cap = sum8; c_cap = cy8;
        end
      end
    end
    chk("midstart_latency", lat, 8);
    chk("midstart_dones", dones, 1);
    chk("midstart_sum", {24'b0, s_cap}, 32'h46);
    chk("midstart_carry", {31'b0, c_cap}, 0);
    chk("midstart_hold", {24'b0, sum8}, 32'h46);

    // reset mid-RUN discards the operation
    @(negedge clk);
    a8 = 8'h0F; b8 = 8'h01; ci8 = 0; st8 = 1;
    @(posedge clk);
    #1 st8 = 0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_sum", {24'b0, sum8}, 0);
    chk("midrst_carry", {31'b0, cy8}, 0);
    chk("midrst_done", {31'b0, dn8}, 0);
    chk("midrst_busy", {31'b0, bsy8}, 0);
    chk("midrst_ready", {31'b0, rdy8}, 1);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0; wb = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (dn8) dones++;
      if (!rdy8) wb++;
    end
    chk("midrst_nodone", dones, 0);
    chk("midrst_idle", wb, 0);

    // STEP=4 with back-to-back acceptance from DONE
    @(negedge clk);
    a4 = 8'hA5; b4 = 8'h5B; ci4 = 1; st4 = 1;
    @(posedge clk);
    #1 st4 = 0;
    k1 = -1; k2 = -1;
    s_cap = 0; c_cap = 0; s2_cap = 0; c2_cap = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (st4) st4 = 0;
      if (dn4) begin
        if (k1 < 0) begin
          k1 = k; s_cap = sum4; c_cap = cy4;
          a4 = 8'h10; b4 = 8'h20; ci4 = 0; st4 = 1;
        end else if (k2 < 0) begin
          k2 = k; s2_cap = sum4; c2_cap = cy4;
        end
      end
    end
    chk("s4_latency", k1, 2);
    chk("s4_sum", {24'b0, s_cap}, 32'h01);
    chk("s4_carry", {31'b0, c_cap}, 1);
    chk("s4_b2b_gap", k2 - k1, 3);
    chk("s4_b2b_sum", {24'b0, s2_cap}, 32'h30);
    chk("s4_b2b_carry", {31'b0, c2_cap}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
